// File: rtl/seven_segment_scan_if.sv
// seven_segment_scan_if
//
// Bundles the scanner's status inputs and its pin-side outputs.
//
// There is no valid/ready handshake on this bus. All inputs are level
// signals that the scanner samples only on its scan tick. All outputs are
// registered levels, except frame_tick, which is a one-cycle pulse.
//
//   msg          4*DIGITS  glyph codes, digit i = msg[4i+3:4i], digit 0 rightmost
//   word_mode    1         0 = hex glyph table, 1 = word glyph table
//   dp           DIGITS    decimal point request per digit
//   blank        DIGITS    force digit dark
//   blink        DIGITS    digit blinks at the blink rate
//   lz_suppress  1         blank leading zero digits (hex mode only)
//   display      7         segments {g,f,e,d,c,b,a}, active-low
//   dp_out       1         decimal point, active-low
//   digit        DIGITS    anode enables, active-low, one-hot-zero
//   frame_tick   1         pulse when the scan wraps back to digit 0
//
// master: the status logic / bench side. slave: the scanner.
interface seven_segment_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] msg;
  logic                word_mode;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   blink;
  logic                lz_suppress;
  logic [6:0]          display;
  logic                dp_out;
  logic [DIGITS-1:0]   digit;
  logic                frame_tick;

  modport master (
    output msg, word_mode, dp, blank, blink, lz_suppress,
    input  display, dp_out, digit, frame_tick
  );

  modport slave (
    input  msg, word_mode, dp, blank, blink, lz_suppress,
    output display, dp_out, digit, frame_tick
  );
endinterface

// File: rtl/seven_segment_scan.sv
// seven_segment_scan
//
// Time-multiplexes DIGITS common-anode seven-segment digits. Each digit is
// lit for REFRESH_DIV clocks. The glyph comes from the hex table or the word
// table, with per-digit decimal point, blanking, blink, and leading-zero
// suppression.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seven_segment_scan_if.slave (status inputs, segment/anode outputs)
//
// The digit enable, the segments and the decimal point all load on the same
// edge (the scan tick), so the outputs never mismatch. The inputs are
// sampled only on that edge.
module seven_segment_scan #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 65536,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_segment_scan_if.slave  bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [RW-1:0]     REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0]     FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

  logic [RW-1:0] refresh_cnt;
  logic [IW-1:0] scan_idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  // Distinguishes the first tick after reset. Reset parks the index at
  // DIGITS-1, and that first wrap to 0 is not a real frame boundary.
  logic          started;

  logic          scan_tick;
  logic          wrap;
  logic [IW-1:0] idx_next;
  logic          frame_event;
  logic          phase_next;
  logic [3:0]    code;
  logic          upper_nz;
  logic          lz_dark;
  logic          dark;
  logic [6:0]    glyph;

  function automatic logic [6:0] hex_glyph(input logic [3:0] c);
    logic [6:0] g;
    unique case (c)
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;  default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Word glyphs: A 1 2 3 4 5 d E i L P r S t U Y
  function automatic logic [6:0] word_glyph(input logic [3:0] c);
    logic [6:0] g;
    unique case (c)
      4'h0: g = 7'b0001000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0100001;  4'h7: g = 7'b0000110;
      4'h8: g = 7'b1111010;  4'h9: g = 7'b1000111;
      4'hA: g = 7'b0001100;  4'hB: g = 7'b0101111;
      4'hC: g = 7'b0010010;  4'hD: g = 7'b0000111;
      4'hE: g = 7'b1000001;  default: g = 7'b0010001;
    endcase
    return g;
  endfunction

  assign scan_tick   = (refresh_cnt == REF_LAST);
  assign wrap        = (scan_idx == IDX_LAST);
  assign idx_next    = wrap ? '0 : scan_idx + 1'b1;
  assign frame_event = scan_tick && wrap && started;

  // The digit-0 slot that opens a new blink half-period already uses the
  // new phase. This lets the first frame after reset count toward the first
  // lit half-period.
  assign phase_next  = (frame_event && (frame_cnt == FRM_LAST)) ? ~blink_phase
                                                                : blink_phase;

  // Select the glyph code for the incoming digit. In the same pass, check
  // whether that digit or any more-significant digit holds a non-zero code.
  always_comb begin
    code     = 4'h0;
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_next) code = bus.msg[4*i +: 4];
      if ((IW'(i) >= idx_next) && (bus.msg[4*i +: 4] != 4'h0)) upper_nz = 1'b1;
    end
  end

  assign lz_dark = bus.lz_suppress && !bus.word_mode && (idx_next != '0) && !upper_nz;
  assign dark    = bus.blank[idx_next] || (bus.blink[idx_next] && phase_next) || lz_dark;
  assign glyph   = bus.word_mode ? word_glyph(code) : hex_glyph(code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt    <= '0;
      scan_idx       <= IDX_LAST;
      frame_cnt      <= '0;
      blink_phase    <= 1'b0;
      started        <= 1'b0;
      bus.digit      <= '1;
      bus.display    <= 7'b1111111;
      bus.dp_out     <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= 1'b0;
      if (scan_tick) begin
        refresh_cnt    <= '0;
        scan_idx       <= idx_next;
        started        <= 1'b1;
        bus.digit      <= ~(ONE_HOT0 << idx_next);
        bus.display    <= dark ? 7'b1111111 : glyph;
        bus.dp_out     <= dark | ~bus.dp[idx_next];
        bus.frame_tick <= frame_event;
        if (frame_event) begin
          frame_cnt   <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
          blink_phase <= phase_next;
        end
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
module tb_seven_segment_scan;

  localparam int DIGITS       = 4;
  localparam int REFRESH_DIV  = 4;
  localparam int BLINK_FRAMES = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_segment_scan_if #(.DIGITS(DIGITS)) bus ();

  seven_segment_scan #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];      // {digit, display, dp_out} per upcoming slot
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_idx    = 0;  // index of the next slot to appear
  int          frame_no = 0;  // digit-0 slots since reset release
  int          exp_ft   = 0;
  int          ft_seen  = 0;
  logic [3:0]  prev_digit = 4'hF;
  int          cyc = 0;

  logic [6:0] hex_ref  [16];
  logic [6:0] word_ref [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of one slot, built from the glyph tables and the
  // dark-slot rules.
  function automatic logic [11:0] exp_slot(input int idx);
    logic [3:0] code;
    logic [6:0] g;
    logic [3:0] d;
    bit         lzd, blk, drk;
    code = bus.msg[4*idx +: 4];
    lzd  = bus.lz_suppress && !bus.word_mode && (idx != 0) && ((bus.msg >> (4*idx)) == 16'h0);
    blk  = bus.blink[idx] && ((((frame_no - 1) / BLINK_FRAMES) % 2) == 1);
    drk  = bus.blank[idx] || blk || lzd;
    g    = bus.word_mode ? word_ref[code] : hex_ref[code];
    d    = ~(4'b0001 << idx);
    return {d, drk ? 7'b1111111 : g, drk ? 1'b1 : ~bus.dp[idx]};
  endfunction

  task automatic predict();
    if (m_idx == 0) begin
      frame_no++;
      if (frame_no > 1) exp_ft++;
    end
    exp_q.push_back(exp_slot(m_idx));
    m_idx = (m_idx + 1) % DIGITS;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [11:0] got;
    logic [11:0] want;
    if (!rst_n) begin
      cyc        = 0;
      prev_digit = bus.digit;
    end else begin
      cyc++;
      if (bus.frame_tick) begin
        ft_seen++;
        chk("frame_tick_digit", 32'(bus.digit), 32'(4'hE));
      end
      if (bus.digit !== prev_digit) begin
        prev_digit = bus.digit;
        chk("slot_length", 32'(cyc), 32'(REFRESH_DIV));
        cyc = 0;
        got = {bus.digit, bus.display, bus.dp_out};
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk("slot", 32'(got), 32'(want));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_slots(input int n);
    for (int k = 0; k < n; k++) begin
      predict();
      repeat (REFRESH_DIV) @(negedge clk);
      #1;
      chk("slot_seen", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    m_idx    = 0;
    frame_no = 0;
    predict();
    repeat (REFRESH_DIV) begin
      chk("pre_tick_dark", 32'(bus.digit), 32'(4'hF));
      @(negedge clk);
      #1;
    end
    chk("first_slot_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic slot_with_change(input logic [15:0] new_msg);
    logic [11:0] held;
    held = {bus.digit, bus.display, bus.dp_out};
    @(negedge clk);
    #1 bus.msg = new_msg;
    predict();
    chk("hold_mid_slot", 32'({bus.digit, bus.display, bus.dp_out}), 32'(held));
    repeat (2) begin
      @(negedge clk);
      #1 chk("hold_mid_slot", 32'({bus.digit, bus.display, bus.dp_out}), 32'(held));
    end
    @(negedge clk);
    #1 chk("changed_slot_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_digit"},      32'(bus.digit),      32'(4'hF));
    chk({tag, "_display"},    32'(bus.display),    32'(7'h7F));
    chk({tag, "_dp_out"},     32'(bus.dp_out),     32'd1);
    chk({tag, "_frame_tick"}, 32'(bus.frame_tick), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    hex_ref  = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    word_ref = '{7'b0001000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0100001, 7'b0000110,
                 7'b1111010, 7'b1000111, 7'b0001100, 7'b0101111,
                 7'b0010010, 7'b0000111, 7'b1000001, 7'b0010001};

    bus.msg         = 16'h1234;
    bus.word_mode   = 1'b0;
    bus.dp          = '0;
    bus.blank       = '0;
    bus.blink       = '0;
    bus.lz_suppress = 1'b0;

    repeat (3) @(negedge clk);
    #1 chk_reset_state("reset");

    // Basic scan of 1234: two full frames.
    release_reset();
    run_slots(7);

    // Leading-zero suppression on and off.
    bus.msg = 16'h0007;
    bus.lz_suppress = 1'b1;
    run_slots(4);
    bus.lz_suppress = 1'b0;
    run_slots(4);

    // Word table: "rEPL".
    bus.word_mode = 1'b1;
    bus.msg = 16'hB7A9;
    run_slots(4);
    bus.word_mode = 1'b0;
    bus.msg = 16'h1234;

    // Decimal point on digit 2 only.
    bus.dp = 4'b0100;
    run_slots(4);
    bus.dp = '0;

    // Blink digit 0 over eight frames, then blank overrides blink.
    bus.blink = 4'b0001;
    run_slots(32);
    bus.blank = 4'b0001;
    run_slots(8);
    bus.blank = '0;
    bus.blink = '0;

    // Mid-slot message change holds until the next tick.
    slot_with_change(16'h5678);
    run_slots(4);

    // Asynchronous reset in the middle of a slot.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("async_reset");
    repeat (2) @(negedge clk);
    release_reset();
    run_slots(7);

    #1;
    chk("frame_tick_count", 32'(ft_seen), 32'(exp_ft));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
